// File: rtl/alu_op_sequencer_if.sv
// Handshake bundle between the instruction source/result consumer and the
// ALU op sequencer: instruction channel in, result channel out.
interface alu_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [2:0]  res_flags;
  logic        res_err;

  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_data, res_flags, res_err
  );

  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_data, res_flags, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer driving an 8-bit combinational ALU: accept instruction, read
// operands from a 4x8 register file, let the ALU settle one cycle, write
// back and hold the result until the consumer takes it.
module alu_op_sequencer #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [2:0]          alu_ctrl,
  input  logic [DW-1:0]       alu_y,
  input  logic                alu_c,
  input  logic                alu_n,
  input  logic                alu_z,
  input  logic [1:0]          dbg_addr,
  output logic [DW-1:0]       dbg_data
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_LDI = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t                 state;
  logic [NREG-1:0][DW-1:0] rf;
  logic [2:0]             flag_q;
  logic [2:0]             op_q;
  logic [1:0]             rd_q;
  logic [DW-1:0]          imm_q;

  logic [2:0] op_i;
  logic [1:0] rd_i, rs1_i, rs2_i;
  logic [7:0] imm_i;

  assign op_i  = bus.in_instr[15:13];
  assign rd_i  = bus.in_instr[12:11];
  assign rs1_i = bus.in_instr[10:9];
  assign rs2_i = bus.in_instr[8:7];
  assign imm_i = bus.in_instr[7:0];

  assign dbg_data = rf[dbg_addr];

  // Decode the ALU code for an incoming instruction; only legal ALU codes
  // ever leave this block, everything non-ALU maps to the idle code.
  logic [2:0] dec_ctrl;
  logic       dec_use;
  always_comb begin
    dec_ctrl = 3'b000;
    dec_use  = 1'b0;
    case (op_i)
      OP_AND, OP_OR, OP_ADD, OP_SUB: begin dec_ctrl = op_i;   dec_use = 1'b1; end
      OP_CMP:                        begin dec_ctrl = OP_SUB; dec_use = 1'b1; end
      default:                       ;
    endcase
  end

  // Result selection at the end of EXEC: ALU output or substituted values.
  logic [DW-1:0] ex_y;
  logic [2:0]    ex_f;
  logic          ex_wb, ex_fw, ex_err;
  always_comb begin
    ex_y   = alu_y;
    ex_f   = {alu_c, alu_n, alu_z};
    ex_wb  = 1'b0;
    ex_fw  = 1'b0;
    ex_err = 1'b0;
    case (op_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB: begin ex_wb = 1'b1; ex_fw = 1'b1; end
      OP_CMP: ex_fw = 1'b1;
      OP_LDI: begin
        ex_y  = imm_q;
        ex_f  = {2'b00, imm_q == '0};
        ex_wb = 1'b1;
        ex_fw = 1'b1;
      end
      OP_NOP: begin ex_y = '0; ex_f = flag_q; end
      default: begin ex_y = '0; ex_f = flag_q; ex_err = 1'b1; end
    endcase
  end

  // Control FSM with registered handshake, ALU-drive and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rf            <= '0;
      flag_q        <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_ctrl      <= '0;
      bus.in_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_flags <= '0;
      bus.res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            op_q         <= op_i;
            rd_q         <= rd_i;
            imm_q        <= imm_i;
            alu_a        <= dec_use ? rf[rs1_i] : '0;
            alu_b        <= dec_use ? rf[rs2_i] : '0;
            alu_ctrl     <= dec_ctrl;
            state        <= EXEC;
          end
        end
        EXEC: begin
          if (ex_wb) rf[rd_q] <= ex_y;
          if (ex_fw) flag_q   <= ex_f;
          bus.res_data  <= ex_y;
          bus.res_flags <= ex_f;
          bus.res_err   <= ex_err;
          bus.res_valid <= 1'b1;
          alu_a         <= '0;
          alu_b         <= '0;
          alu_ctrl      <= 3'b000;
          state         <= WB;
        end
        WB: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + random check of alu_op_sequencer against a behavioural ALU.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] alu_a, alu_b, alu_y, dbg_data;
  logic [2:0] alu_ctrl;
  logic       alu_c, alu_n, alu_z;
  logic [1:0] dbg_addr = 2'd0;

  alu_op_sequencer_if bus();

  alu_op_sequencer dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: C=carry for ADD, C=N=borrow for SUB, X on bad codes.
  logic [8:0] s;
  always_comb begin
    s = '0;
    case (alu_ctrl)
      3'b000:  s = {1'b0, alu_a & alu_b};
      3'b001:  s = {1'b0, alu_a | alu_b};
      3'b010:  s = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  s = {1'b0, alu_a} - {1'b0, alu_b};
      default: s = 'x;
    endcase
    alu_y = s[7:0];
    alu_c = s[8];
    alu_n = (alu_ctrl == 3'b110) ? s[8] : 1'b0;
    alu_z = (s[7:0] == 8'h00);
  end

  // ALU must only ever see its four defined codes.
  always @(negedge clk)
    if (!rst)
      assert (alu_ctrl inside {3'b000, 3'b001, 3'b010, 3'b110})
        else $error("illegal alu_ctrl %b", alu_ctrl);

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b011, rd, 3'b000, imm};
  endfunction

  function automatic logic [15:0] rr(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] r1, input logic [1:0] r2);
    return {op, rd, r1, r2, 7'b0};
  endfunction

  logic [7:0] r_d;
  logic [2:0] r_f, ex_ctrl, wb_ctrl;
  logic       r_e;

  // Issue one instruction from a negedge; returns at the negedge after the
  // result was consumed, FSM back in IDLE.
  task automatic run(input logic [15:0] i, input int stall);
    int n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("accept_timeout", {31'b0, bus.in_ready}, 1);
    bus.in_valid = 1'b1;
    bus.in_instr = i;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    ex_ctrl = alu_ctrl;
    @(negedge clk);
    check("res_valid", {31'b0, bus.res_valid}, 1);
    wb_ctrl = alu_ctrl;
    r_d = bus.res_data;
    r_f = bus.res_flags;
    r_e = bus.res_err;
    for (int k = 0; k < stall; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = ldi(2'd0, 8'hAA);
      @(negedge clk);
      check("stall_valid", {31'b0, bus.res_valid}, 1);
      check("stall_data", {24'b0, bus.res_data}, {24'b0, r_d});
      check("stall_in_ready", {31'b0, bus.in_ready}, 0);
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("idle_in_ready", {31'b0, bus.in_ready}, 1);
    check("res_valid_drop", {31'b0, bus.res_valid}, 0);
  endtask

  task automatic dbg(input logic [1:0] a, input logic [7:0] exp, input string tag);
    dbg_addr = a;
    #1;
    check(tag, {24'b0, dbg_data}, {24'b0, exp});
  endtask

  logic [7:0]  m [4];
  logic [2:0]  mf;
  logic [15:0] ri;
  logic [8:0]  t;
  logic [7:0]  ed;
  logic [2:0]  ef;
  logic        ee, ewb, efw;
  int          seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.res_ready = 1'b0;

    // Reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 0);
    check("rst_res_valid", {31'b0, bus.res_valid}, 0);
    check("rst_outs", {alu_a, alu_b, alu_ctrl, bus.res_data, bus.res_flags, bus.res_err}, 0);
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) dbg(a[1:0], 8'h00, "rst_dbg");
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_in_ready", {31'b0, bus.in_ready}, 1);

    // Basic ADD, with a 5-cycle result stall
    run(ldi(2'd1, 8'h7F), 0); check("ldi_7f", {24'b0, r_d}, 32'h7F);
    run(ldi(2'd2, 8'h01), 0); check("ldi_01_flags", {29'b0, r_f}, 0);
    run(rr(3'b010, 2'd3, 2'd1, 2'd2), 5);
    check("add_data", {24'b0, r_d}, 32'h80);
    check("add_flags", {29'b0, r_f}, 3'b000);
    check("add_exec_ctrl", {29'b0, ex_ctrl}, 3'b010);
    check("add_wb_ctrl", {29'b0, wb_ctrl}, 3'b000);
    dbg(2'd3, 8'h80, "dbg_r3");
    dbg(2'd0, 8'h00, "stall_ignored_r0");

    // Wrap, subtract with borrow, compare
    run(ldi(2'd1, 8'hFF), 0);
    run(rr(3'b010, 2'd0, 2'd1, 2'd2), 0);
    check("addwrap_data", {24'b0, r_d}, 32'h00);
    check("addwrap_flags", {29'b0, r_f}, 3'b101);
    run(ldi(2'd1, 8'h05), 0);
    run(ldi(2'd2, 8'h07), 0);
    run(rr(3'b110, 2'd0, 2'd1, 2'd2), 0);
    check("sub_data", {24'b0, r_d}, 32'hFE);
    check("sub_flags", {29'b0, r_f}, 3'b110);
    check("sub_exec_ctrl", {29'b0, ex_ctrl}, 3'b110);
    run(rr(3'b100, 2'd0, 2'd1, 2'd1), 0);
    check("cmp_flags", {29'b0, r_f}, 3'b001);
    check("cmp_exec_ctrl", {29'b0, ex_ctrl}, 3'b110);
    dbg(2'd0, 8'hFE, "cmp_no_wb");

    // Illegal opcode and NOP leave regfile/flags untouched
    run(rr(3'b111, 2'd1, 2'd2, 2'd2), 0);
    check("ill_err", {31'b0, r_e}, 1);
    check("ill_data", {24'b0, r_d}, 0);
    check("ill_exec_ctrl", {29'b0, ex_ctrl}, 0);
    dbg(2'd1, 8'h05, "ill_no_wb");
    run(rr(3'b101, 2'd1, 2'd1, 2'd1), 0);
    check("nop_err", {31'b0, r_e}, 0);
    check("nop_data", {24'b0, r_d}, 0);
    check("nop_flags_kept", {29'b0, r_f}, 3'b001);

    // OR/AND and rd==rs1==rs2
    run(rr(3'b001, 2'd3, 2'd1, 2'd2), 0);
    check("or_data", {24'b0, r_d}, 32'h07);
    run(rr(3'b000, 2'd3, 2'd1, 2'd2), 0);
    check("and_data", {24'b0, r_d}, 32'h05);
    run(rr(3'b010, 2'd2, 2'd2, 2'd2), 0);
    check("self_add", {24'b0, r_d}, 32'h0E);
    dbg(2'd2, 8'h0E, "self_add_wb");

    // Reset during EXEC of ADD r3
    bus.in_valid = 1'b1;
    bus.in_instr = rr(3'b010, 2'd3, 2'd1, 2'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    check("rst_exec_no_valid", seen, 0);
    check("rst_exec_in_ready", {31'b0, bus.in_ready}, 1);
    dbg(2'd3, 8'h00, "rst_exec_r3");

    // Random run against a spec-level model
    for (int a = 0; a < 4; a++) m[a] = 8'h00;
    mf = 3'b000;
    for (int n = 0; n < 1000; n++) begin
      ri = $urandom;
      ee = 1'b0; ewb = 1'b0; efw = 1'b0; ed = 8'h00; ef = mf;
      case (ri[15:13])
        3'b000: begin ed = m[ri[10:9]] & m[ri[8:7]]; ef = {2'b00, ed == 0}; ewb = 1; efw = 1; end
        3'b001: begin ed = m[ri[10:9]] | m[ri[8:7]]; ef = {2'b00, ed == 0}; ewb = 1; efw = 1; end
        3'b010: begin
          t = {1'b0, m[ri[10:9]]} + {1'b0, m[ri[8:7]]};
          ed = t[7:0]; ef = {t[8], 1'b0, ed == 0}; ewb = 1; efw = 1;
        end
        3'b110, 3'b100: begin
          t = {1'b0, m[ri[10:9]]} - {1'b0, m[ri[8:7]]};
          ed = t[7:0]; ef = {t[8], t[8], ed == 0}; ewb = (ri[15:13] == 3'b110); efw = 1;
        end
        3'b011: begin ed = ri[7:0]; ef = {2'b00, ed == 0}; ewb = 1; efw = 1; end
        3'b101: ;
        default: ee = 1'b1;
      endcase
      run(ri, 0);
      check("rnd_data", {24'b0, r_d}, {24'b0, ed});
      check("rnd_flags", {29'b0, r_f}, {29'b0, ef});
      check("rnd_err", {31'b0, r_e}, {31'b0, ee});
      if (ewb) m[ri[12:11]] = ed;
      if (efw) mf = ef;
    end
    for (int a = 0; a < 4; a++) dbg(a[1:0], m[a], "rnd_final_rf");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator for the 8-bit combinational ALU (ops AND/OR/ADD/SUB, flags C/N/Z). It accepts 16-bit instructions over a valid/ready handshake and reads operands from a 4x8 register file. It drives the ALU operand and control inputs, captures the ALU result and flags, writes back, and presents the result over a second valid/ready handshake. It sits between the instruction source and the ALU datapath.

Parameters:
DW, 8, data width; fixed at 8 to match the ALU.
NREG, 4, register file depth; 2-bit register addresses.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  instruction valid
in_ready  out  1  sequencer can accept an instruction
in_instr  in  16  [15:13] op, [12:11] rd, [10:9] rs1, [8:7] rs2, [7:0] imm (LDI only)
alu_a  out  8  ALU operand A (registered)
alu_b  out  8  ALU operand B (registered)
alu_ctrl  out  3  ALU control (registered)
alu_y  in  8  ALU result
alu_c  in  1  ALU carry/borrow
alu_n  in  1  ALU negative
alu_z  in  1  ALU zero
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  8  result value
res_flags  out  3  {C,N,Z} of this instruction
res_err  out  1  illegal opcode
dbg_addr  in  2  debug register read address
dbg_data  out  8  regfile[dbg_addr], combinational

Behaviour:
- Reset (async, rst=1): state=IDLE, all registers 0, flag register 0, alu_a/alu_b/alu_ctrl=0, res_valid=0, res_data=0, res_flags=0, res_err=0, in_ready=0 while rst is high.
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB: alu_ctrl = op, written back to rd.
  - 011 LDI: rd = imm; flags C=0, N=0, Z=(imm==0).
  - 100 CMP: alu_ctrl=110; flags updated; no writeback.
  - 101 NOP: no writeback; flags unchanged; res_data=0.
  - 111 illegal: res_err=1; no writeback; flags unchanged.
- The sequencer must never drive alu_ctrl values other than 000/001/010/110, because the ALU outputs X for any other code. Idle value is 000.
- FSM: IDLE -> EXEC -> WB -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch the instruction, load alu_a=reg[rs1], alu_b=reg[rs2], alu_ctrl=decoded code. For LDI/NOP/illegal, load alu_a=alu_b=0 and alu_ctrl=000.
  - EXEC (1 cycle): in_ready=0; ALU settles. At the closing edge:
    - sample alu_y/alu_c/alu_n/alu_z, or substitute LDI/NOP values;
    - write rd and the flag register as the op requires;
    - load res_*;
    - set res_valid=1;
    - return alu_a/alu_b/alu_ctrl to 0.
  - WB: res_valid=1; res_data/res_flags/res_err held stable. On res_ready=1 at an edge: res_valid=0, res_err=0, go to IDLE. res_ready low stalls indefinitely with outputs stable.
- Latency: accept edge T; result visible after edge T+1; earliest next accept at edge T+3 (if res_ready=1 during WB). Throughput is 1 instruction per 3 cycles.
- No hazards: writeback completes before the next accept, so a following instruction reads the updated value.
- in_valid while in_ready=0 is ignored; the source must hold it.
- rd == rs1 == rs2 is legal; operands are read before the write.
- res_flags for AND/OR: C=0, N=0 as supplied by the ALU.
- res_flags for SUB/CMP: C=borrow, N=borrow.
- ADD wraps mod 256, with C=carry out.
- Reset asserted mid-EXEC or mid-WB: the instruction is discarded, there is no writeback, and the reset values above apply immediately.
- dbg_data reflects a writeback from the cycle after the write edge.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0, in_ready=0; release -> in_ready=1; dbg_data=0 for addresses 0..3.
- LDI r1,0x7F; LDI r2,0x01; ADD r3,r1,r2 -> res_data=0x80, flags {0,0,0}, dbg r3=0x80, alu_ctrl=010 only during EXEC.
- LDI r1,0xFF; ADD r0,r1,r2 (r2=0x01) -> res_data=0x00, flags {1,0,1}. Then LDI 0x05/0x07 and SUB -> 0xFE, flags {1,1,0}. Then CMP r1,r1 -> flags {0,0,1}, r0 unchanged.
- Hold res_ready=0 for 5 cycles after ADD -> res_valid stays 1, res_data stable, in_ready=0, a new in_valid is ignored. Release -> next accept exactly 1 cycle later.
- Op 111 -> res_err=1; regfile and flags unchanged; alu_ctrl never outside {000,001,010,110} over a 1000-instruction random run (assertion).
- Assert rst during EXEC of ADD r3 -> r3 remains 0, res_valid never rises, FSM restarts in IDLE.
